spi_cmd_decoder: RTL
====================

Name: spi_cmd_decoder

Overview:
Sits directly downstream of the SPI target (spi1) and upstream of the bus arbiter/BRAM port. It assembles command bytes received over SPI into single-byte read/write requests on the 17-bit bus, holds each request until the arbiter completes it, and presents read data back to the SPI target for shifting out. It keeps an internal address register so the MCU can stream sequential accesses with 1- or 2-byte commands.

Parameters:
ADDR_WIDTH, 17, bus address width (A16 carried in bit 0 of command byte)
DATA_WIDTH, 8, bus and SPI byte width

Ports:
clock_i  in  1  system clock (64 MHz)
reset_n_i  in  1  asynchronous active-low reset
spi_start_i  in  1  one-cycle pulse: CS asserted, new transaction begins
spi_valid_i  in  1  one-cycle pulse: spi_rx_i holds a complete received byte
spi_rx_i  in  8  received byte
spi_tx_o  out  8  byte the SPI target shifts out on the next transfer (last read result)
spi_stall_o  out  1  high while a bus request is pending; MCU must poll before the next command
bus_addr_o  out  17  request address
bus_data_o  out  8  write data
bus_rd_o  out  1  read request, level, held until bus_done_i
bus_wr_o  out  1  write request, level, held until bus_done_i
bus_done_i  in  1  one-cycle pulse: arbiter completed current request
bus_data_i  in  8  read data, valid on the bus_done_i cycle
err_o  out  1  sticky overrun flag; set by a byte received while PENDING

Behaviour:
- Clock and reset: single clock clock_i; reset_n_i asynchronous assert, active-low. Reset: all outputs 0, state IDLE, address register 0.
- Command byte: [7:6] opcode, [5:1] ignored, [0] = A16.
  - 2'b00 READ_NEXT: 1 byte. addr <= addr+1, then read.
  - 2'b01 WRITE_NEXT: cmd, data. addr <= addr+1, then write data.
  - 2'b10 WRITE_AT: cmd, data, addr_hi, addr_lo. addr <= {A16, hi, lo}, then write.
  - 2'b11 READ_AT: cmd, addr_hi, addr_lo. addr <= {A16, hi, lo}, then read.
- Increment is modulo 2^17: 17'h1FFFF+1 -> 17'h00000. A16 in a _NEXT command byte is ignored.
- FSM states: IDLE, DATA, ADDR_HI, ADDR_LO, PENDING.
  - IDLE --valid--> latch opcode/A16. READ_NEXT -> PENDING. WRITE_* -> DATA. READ_AT -> ADDR_HI.
  - DATA --valid--> latch data. WRITE_NEXT -> PENDING. WRITE_AT -> ADDR_HI.
  - ADDR_HI --valid--> ADDR_LO.
  - ADDR_LO --valid--> PENDING.
  - PENDING: on bus_done_i -> IDLE. On a read, spi_tx_o <= bus_data_i in that cycle.
- Request timing:
  - bus_rd_o/bus_wr_o, bus_addr_o and bus_data_o are registered and assert the cycle after the final byte's spi_valid_i.
  - All of them stay stable until bus_done_i.
  - Request drops the cycle after bus_done_i.
  - spi_stall_o == (state == PENDING).
  - Only one of bus_rd_o/bus_wr_o is ever high.
- spi_start_i:
  - In IDLE/DATA/ADDR_*: aborts any partial command -> IDLE. Address register unchanged. err_o cleared.
  - In PENDING: request completes normally, then -> IDLE. err_o cleared.
- Simultaneous events:
  - spi_start_i and spi_valid_i in the same cycle: start is processed first, and the byte is treated as a command byte.
  - spi_valid_i while PENDING: byte discarded, err_o <= 1.
  - bus_done_i outside PENDING: ignored.
- Reset mid-request: request drops immediately, with no completion.

Decomposition:
- Package spi_cmd_pkg:
  - opcode typedef enum logic [1:0] {READ_NEXT, WRITE_NEXT, WRITE_AT, READ_AT}.
  - State enum.
  - Localparams for field positions (OP_MSB=7, OP_LSB=6, A16_BIT=0).
- Shared by spi_cmd_decoder and the MCU-side bench driver.
- No sub-module: the FSM plus address/data registers fit in one module of about 180 lines.

Test Plan:
- WRITE_AT: reset, then start, then bytes 8'h81, 8'h5A, 8'h23, 8'h45.
  - Expect bus_wr_o=1, bus_addr_o=17'h12345, bus_data_o=8'h5A, spi_stall_o=1.
  - Expect both to drop the cycle after bus_done_i.
- READ_AT then READ_NEXT:
  - Send bytes 8'hC0, 8'h80, 8'h00 -> bus_rd_o @17'h08000. Reply bus_data_i=8'hA5 with done -> spi_tx_o=8'hA5.
  - Then send 8'h00 -> read @17'h08001.
- WRITE_NEXT wrap: set addr 17'h1FFFF via WRITE_AT, then send 8'h40, 8'h77 -> write 8'h77 @17'h00000.
- Abort: send 8'h80, 8'h11, then pulse spi_start_i, then send 8'h00.
  - Expect no write.
  - READ_NEXT uses the prior address+1.
- Overrun: pulse spi_valid_i while PENDING.
  - Expect err_o=1 and the request unchanged.
  - Next spi_start_i clears err_o.
- Async reset: assert reset_n_i low mid-PENDING with no clock edge.
  - All outputs go to 0 immediately.
  - After release, the state is IDLE.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared command/state definitions for the SPI command decoder and its MCU-side driver.
package spi_cmd_pkg;

  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned A16_BIT = 0;

  typedef enum logic [1:0] {
    READ_NEXT  = 2'b00,
    WRITE_NEXT = 2'b01,
    WRITE_AT   = 2'b10,
    READ_AT    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    PENDING = 3'd4
  } state_e;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Assembles SPI command bytes into single-byte bus read/write requests and returns read data.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  spi_start_i,
  input  logic                  spi_valid_i,
  input  logic [DATA_WIDTH-1:0] spi_rx_i,
  output logic [DATA_WIDTH-1:0] spi_tx_o,
  output logic                  spi_stall_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_rd_o,
  output logic                  bus_wr_o,
  input  logic                  bus_done_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  err_o
);

  state_e                state_q, state_d, cur_st;
  op_e                   op_q, op_d, cmd_op;
  logic                  a16_q, a16_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      op_q       <= READ_NEXT;
      a16_q      <= 1'b0;
      wdata_q    <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      bus_data_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      tx_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a16_q      <= a16_d;
      wdata_q    <= wdata_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      bus_data_q <= bus_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
    end
  end

  // Command parsing, request issue and completion
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a16_d      = a16_q;
    wdata_d    = wdata_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    bus_data_d = bus_data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    tx_d       = tx_q;
    err_d      = err_q;
    cur_st     = state_q;
    cmd_op     = op_e'(spi_rx_i[OP_MSB:OP_LSB]);

    if (state_q == PENDING) begin
      // A start here only clears the flag; the request still runs to completion.
      if (spi_start_i) err_d = 1'b0;
      if (spi_valid_i) err_d = 1'b1;
      if (bus_done_i) begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        if (rd_q) tx_d = bus_data_i;
      end
    end else begin
      if (spi_start_i) begin
        cur_st  = IDLE;
        state_d = IDLE;
        err_d   = 1'b0;
      end
      if (spi_valid_i) begin
        case (cur_st)
          IDLE: begin
            op_d  = cmd_op;
            a16_d = spi_rx_i[A16_BIT];
            case (cmd_op)
              READ_NEXT: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                rd_d    = 1'b1;
                state_d = PENDING;
              end
              READ_AT: state_d = ADDR_HI;
              default: state_d = DATA;
            endcase
          end
          DATA: begin
            wdata_d = spi_rx_i;
            if (op_q == WRITE_NEXT) begin
              addr_d     = addr_q + ADDR_WIDTH'(1);
              bus_data_d = spi_rx_i;
              wr_d       = 1'b1;
              state_d    = PENDING;
            end else begin
              state_d = ADDR_HI;
            end
          end
          ADDR_HI: begin
            hi_d    = spi_rx_i;
            state_d = ADDR_LO;
          end
          ADDR_LO: begin
            addr_d  = ADDR_WIDTH'({a16_q, hi_q, spi_rx_i});
            state_d = PENDING;
            if (op_q == WRITE_AT) begin
              bus_data_d = wdata_q;
              wr_d       = 1'b1;
            end else begin
              rd_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign spi_tx_o    = tx_q;
  assign spi_stall_o = (state_q == PENDING);
  assign bus_addr_o  = addr_q;
  assign bus_data_o  = bus_data_q;
  assign bus_rd_o    = rd_q;
  assign bus_wr_o    = wr_q;
  assign err_o       = err_q;

endmodule
